// File: rtl/sdr_init_refresh_ctrl_if.sv
// SDRAM command bus plus refresh handshake between the init/refresh block
// (master) and the main transfer controller / SDRAM side (slave).
// Optional macro SDR_EXT_MODE_EN adds the extended mode register value.
interface sdr_init_refresh_ctrl_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
);
  logic [ADDR_W-1:0] cfg_mode_reg;
`ifdef SDR_EXT_MODE_EN
  logic [ADDR_W-1:0] cfg_ext_mode_reg;
`endif
  logic              ref_gnt;
  logic              sdr_cke;
  logic              sdr_cs_n;
  logic              sdr_ras_n;
  logic              sdr_cas_n;
  logic              sdr_we_n;
  logic [ADDR_W-1:0] sdr_addr;
  logic [BA_W-1:0]   sdr_ba;
  logic              cmd_own;
  logic              init_done;
  logic              ref_req;
  logic              ref_ovf;

  modport master (
`ifdef SDR_EXT_MODE_EN
    input  cfg_ext_mode_reg,
`endif
    input  cfg_mode_reg,
    input  ref_gnt,
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    output sdr_addr, sdr_ba,
    output cmd_own, init_done, ref_req, ref_ovf
  );

  modport slave (
`ifdef SDR_EXT_MODE_EN
    output cfg_ext_mode_reg,
`endif
    output cfg_mode_reg,
    output ref_gnt,
    input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    input  sdr_addr, sdr_ba,
    input  cmd_own, init_done, ref_req, ref_ovf
  );
endinterface

// File: rtl/sdr_init_refresh_ctrl.sv
// SDRAM power-up initialization sequencer and periodic auto-refresh scheduler.
// Owns the command bus until init completes, then requests the bus for refresh.
// Optional macro SDR_EXT_MODE_EN inserts an EMRS (ba=2'b10) after the MRS.
module sdr_init_refresh_ctrl #(
  parameter int unsigned INIT_WAIT    = 600,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned REF_INIT_CNT = 2,
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned BA_W         = 2
) (
  input logic                     sdram_clk,
  input logic                     sdram_reset,
  sdr_init_refresh_ctrl_if.master bus
);

  localparam int unsigned M1      = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned M2      = (M1 > T_MRD) ? M1 : T_MRD;
  localparam int unsigned CNT_MAX = (M2 > INIT_WAIT) ? M2 : INIT_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMR_W   = $clog2(REF_INTERVAL + 1);
  localparam int unsigned AREF_W  = $clog2(REF_INIT_CNT + 1);

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  typedef enum logic [3:0] {
    S_WAIT_PWR, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC,
    S_MRS, S_WAIT_MRD, S_EMRS, S_WAIT_EMRD, S_IDLE
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [AREF_W-1:0]   aref_cnt, aref_cnt_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [2:0]          pend, pend_n;
  logic                wrap, grant;
  logic                ovf_n, done_n, req_n, own_n;
  logic [2:0]          cmd_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [BA_W-1:0]     ba_n;

  // State, counters and registered command-bus outputs
  always_ff @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset) begin
      state         <= S_WAIT_PWR;
      cnt           <= '0;
      aref_cnt      <= '0;
      timer         <= '0;
      pend          <= '0;
      bus.sdr_cke   <= 1'b0;
      bus.sdr_cs_n  <= 1'b0;
      bus.sdr_ras_n <= 1'b1;
      bus.sdr_cas_n <= 1'b1;
      bus.sdr_we_n  <= 1'b1;
      bus.sdr_addr  <= '0;
      bus.sdr_ba    <= '0;
      bus.cmd_own   <= 1'b1;
      bus.init_done <= 1'b0;
      bus.ref_req   <= 1'b0;
      bus.ref_ovf   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      aref_cnt      <= aref_cnt_n;
      timer         <= timer_n;
      pend          <= pend_n;
      bus.sdr_cke   <= 1'b1;
      bus.sdr_cs_n  <= 1'b0;
      {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= cmd_n;
      bus.sdr_addr  <= addr_n;
      bus.sdr_ba    <= ba_n;
      bus.cmd_own   <= own_n;
      bus.init_done <= done_n;
      bus.ref_req   <= req_n;
      bus.ref_ovf   <= ovf_n;
    end
  end

  // Next state, refresh bookkeeping and decode of the command for the next cycle
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    aref_cnt_n = aref_cnt;
    cmd_n      = CMD_NOP;
    addr_n     = '0;
    ba_n       = '0;

    // ref_req is only ever high in IDLE, so it doubles as the IDLE qualifier
    grant = bus.ref_req & bus.ref_gnt;
    wrap  = bus.init_done && (timer == TMR_W'(REF_INTERVAL - 1));

    case (state)
      S_WAIT_PWR: begin
        if (cnt == CNT_W'(INIT_WAIT)) begin
          state_n = S_PRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PRE: state_n = S_WAIT_RP;
      S_WAIT_RP: begin
        if (cnt == CNT_W'(T_RP - 1)) begin
          state_n = S_AREF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_AREF: state_n = S_WAIT_RFC;
      S_WAIT_RFC: begin
        if (cnt == CNT_W'(T_RFC - 1)) begin
          cnt_n = '0;
          if (bus.init_done) begin
            state_n = S_IDLE;
          end else if (aref_cnt == AREF_W'(REF_INIT_CNT - 1)) begin
            state_n    = S_MRS;
            aref_cnt_n = '0;
          end else begin
            state_n    = S_AREF;
            aref_cnt_n = aref_cnt + AREF_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_MRS: state_n = S_WAIT_MRD;
      S_WAIT_MRD: begin
        if (cnt == CNT_W'(T_MRD - 1)) begin
          cnt_n = '0;
`ifdef SDR_EXT_MODE_EN
          state_n = S_EMRS;
`else
          state_n = S_IDLE;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef SDR_EXT_MODE_EN
      S_EMRS: state_n = S_WAIT_EMRD;
      S_WAIT_EMRD: begin
        if (cnt == CNT_W'(T_MRD - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      S_IDLE: if (grant) state_n = S_AREF;
      default: state_n = S_WAIT_PWR;
    endcase

    // Refresh interval timer runs from the first IDLE cycle onwards
    timer_n = (!bus.init_done || wrap) ? '0 : timer + TMR_W'(1);

    pend_n = pend;
    if (wrap && !grant) begin
      if (pend != 3'd7) pend_n = pend + 3'd1;
    end else if (grant && !wrap) begin
      pend_n = pend - 3'd1;
    end
    ovf_n = bus.ref_ovf | (wrap && (pend == 3'd7));

    done_n = bus.init_done | (state_n == S_IDLE);
    own_n  = (state_n != S_IDLE);
    req_n  = (pend_n != 3'd0) && (state_n == S_IDLE);

    case (state_n)
      S_PRE: begin
        cmd_n      = CMD_PRE;
        addr_n[10] = 1'b1;
      end
      S_AREF: cmd_n = CMD_AREF;
      S_MRS: begin
        cmd_n  = CMD_MRS;
        addr_n = bus.cfg_mode_reg;
      end
`ifdef SDR_EXT_MODE_EN
      S_EMRS: begin
        cmd_n  = CMD_MRS;
        addr_n = bus.cfg_ext_mode_reg;
        ba_n   = BA_W'(2);
      end
`endif
      default: cmd_n = CMD_NOP;
    endcase
  end

endmodule

// File: tb/tb_sdr_init_refresh_ctrl.sv
// Directed bench for sdr_init_refresh_ctrl: init sequence timing, refresh
// handshake, wrap/grant coincidence, mid-init reset and pend saturation.
module tb_sdr_init_refresh_ctrl;

  localparam int RI = 780;
`ifdef SDR_EXT_MODE_EN
  localparam int INIT_END = 625;
`else
  localparam int INIT_END = 622;
`endif

  logic sdram_clk   = 1'b0;
  logic sdram_reset = 1'b1;
  int   cyc         = -1;
  int   n_cmp       = 0;
  int   n_fail      = 0;

  sdr_init_refresh_ctrl_if #(.ADDR_W(13), .BA_W(2)) bus ();

  sdr_init_refresh_ctrl dut (
    .sdram_clk  (sdram_clk),
    .sdram_reset(sdram_reset),
    .bus        (bus)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Cycle index: 0 on the first rising edge after reset release
  always @(posedge sdram_clk) cyc <= sdram_reset ? -1 : cyc + 1;

  wire [2:0] cmd = {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};

  task automatic wait_to(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(negedge sdram_clk);
      guard++;
      if (guard > 20000) begin
        n_cmp++; n_fail++;
        $display("FAIL wait_to timeout: cyc=%0d target=%0d", cyc, n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge sdram_clk);
    sdram_reset = 1'b1;
    repeat (3) @(negedge sdram_clk);
    sdram_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] exp_v;
    bus.cfg_mode_reg = 13'h033;
`ifdef SDR_EXT_MODE_EN
    bus.cfg_ext_mode_reg = 13'h0a5;
`endif
    bus.ref_gnt = 1'b0;
    sdram_reset = 1'b1;
    repeat (2) @(negedge sdram_clk);
    exp_v = {1'b0, 1'b0, 3'b111, 13'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if ({bus.sdr_cke, bus.sdr_cs_n, cmd, bus.sdr_addr, bus.sdr_ba, bus.cmd_own,
         bus.init_done, bus.ref_req, bus.ref_ovf} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h",
               {bus.sdr_cke, bus.sdr_cs_n, cmd, bus.sdr_addr, bus.sdr_ba, bus.cmd_own,
                bus.init_done, bus.ref_req, bus.ref_ovf}, exp_v);
    end
    sdram_reset = 1'b0;
  endtask

  task automatic test_init();
    logic [2:0] ec;
    for (int c = 0; c <= INIT_END; c++) begin
      wait_to(c);
      if (c == 300) bus.ref_gnt = 1'b1;  // must be ignored during init
      ec = 3'b111;
      if (c == 600) ec = 3'b010;
      if (c == 603 || c == 611) ec = 3'b001;
      if (c == 619) ec = 3'b000;
`ifdef SDR_EXT_MODE_EN
      if (c == 622) ec = 3'b000;
`endif
      n_cmp++;
      if ({bus.sdr_cke, bus.sdr_cs_n, cmd, bus.cmd_own, bus.init_done, bus.ref_req} !==
          {1'b1, 1'b0, ec, 1'(c < INIT_END), 1'(c >= INIT_END), 1'b0}) begin
        n_fail++;
        $display("FAIL init_cycle %0d: cke/cs/cmd/own/done/req got %b want %b", c,
                 {bus.sdr_cke, bus.sdr_cs_n, cmd, bus.cmd_own, bus.init_done, bus.ref_req},
                 {1'b1, 1'b0, ec, 1'(c < INIT_END), 1'(c >= INIT_END), 1'b0});
      end
      if (c == 600) begin
        n_cmp++;
        if (bus.sdr_addr[10] !== 1'b1) begin
          n_fail++;
          $display("FAIL pre_a10: got %b want 1", bus.sdr_addr[10]);
        end
      end
      if (c == 619) begin
        n_cmp++;
        if ({bus.sdr_ba, bus.sdr_addr} !== {2'b00, 13'h033}) begin
          n_fail++;
          $display("FAIL mrs_addr: got ba=%b addr=%h want ba=00 addr=033",
                   bus.sdr_ba, bus.sdr_addr);
        end
      end
`ifdef SDR_EXT_MODE_EN
      if (c == 622) begin
        n_cmp++;
        if ({bus.sdr_ba, bus.sdr_addr} !== {2'b10, 13'h0a5}) begin
          n_fail++;
          $display("FAIL emrs_addr: got ba=%b addr=%h want ba=10 addr=0a5",
                   bus.sdr_ba, bus.sdr_addr);
        end
      end
`endif
    end
  endtask

  task automatic test_refresh_tied();
    int b = INIT_END + RI;
    logic [4:0] got, want;
    for (int c = INIT_END + 1; c <= b + 9; c++) begin
      wait_to(c);
      want = {1'(c == b), 1'(c >= b + 1 && c <= b + 8), (c == b + 1) ? 3'b001 : 3'b111};
      got  = {bus.ref_req, bus.cmd_own, cmd};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL tied_refresh cycle %0d: req/own/cmd got %b want %b", c, got, want);
      end
    end
    bus.ref_gnt = 1'b0;
  endtask

  task automatic test_wrap_with_grant();
    int w2 = INIT_END + 2 * RI;
    int w3 = INIT_END + 3 * RI;
    wait_to(w2 - 1);
    n_cmp++;
    if (bus.ref_req !== 1'b0) begin
      n_fail++; $display("FAIL pre_wrap_req: got %b want 0", bus.ref_req);
    end
    wait_to(w2);
    n_cmp++;
    if (bus.ref_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_req: got %b want 1", bus.ref_req);
    end
    wait_to(w3 - 1);
    bus.ref_gnt = 1'b1;
    wait_to(w3);
    bus.ref_gnt = 1'b0;
    n_cmp++;
    if ({cmd, bus.ref_req, bus.cmd_own} !== {3'b001, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL coincident_aref: cmd/req/own got %b want 00101", {cmd, bus.ref_req, bus.cmd_own});
    end
    wait_to(w3 + 8);
    n_cmp++;
    if ({cmd, bus.ref_req, bus.cmd_own} !== {3'b111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL coincident_rereq: cmd/req/own got %b want 11110", {cmd, bus.ref_req, bus.cmd_own});
    end
    bus.ref_gnt = 1'b1;
    wait_to(w3 + 9);
    bus.ref_gnt = 1'b0;
    n_cmp++;
    if (cmd !== 3'b001) begin
      n_fail++; $display("FAIL second_aref: cmd got %b want 001", cmd);
    end
    wait_to(w3 + 17);
    n_cmp++;
    if ({bus.ref_req, bus.cmd_own, bus.ref_ovf} !== 3'b000) begin
      n_fail++;
      $display("FAIL pend_drained: req/own/ovf got %b want 000", {bus.ref_req, bus.cmd_own, bus.ref_ovf});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_to(605);
    n_cmp++;
    if ({bus.sdr_cke, bus.cmd_own, cmd} !== {1'b1, 1'b1, 3'b111}) begin
      n_fail++; $display("FAIL in_wait_rp: cke/own/cmd got %b want 11111", {bus.sdr_cke, bus.cmd_own, cmd});
    end
    #2 sdram_reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.sdr_cke, bus.sdr_cs_n, cmd, bus.sdr_addr, bus.cmd_own, bus.init_done} !==
        {1'b0, 1'b0, 3'b111, 13'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got cke=%b cs=%b cmd=%b addr=%h own=%b done=%b",
               bus.sdr_cke, bus.sdr_cs_n, cmd, bus.sdr_addr, bus.cmd_own, bus.init_done);
    end
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    sdram_reset = 1'b0;
    for (int c = 0; c <= 600; c++) begin
      wait_to(c);
      n_cmp++;
      if (cmd !== ((c == 600) ? 3'b010 : 3'b111)) begin
        n_fail++;
        $display("FAIL reinit_cycle %0d: cmd got %b want %b", c, cmd, (c == 600) ? 3'b010 : 3'b111);
      end
    end
    wait_to(INIT_END);
    n_cmp++;
    if ({bus.init_done, bus.cmd_own} !== 2'b10) begin
      n_fail++; $display("FAIL reinit_done: done/own got %b want 10", {bus.init_done, bus.cmd_own});
    end
  endtask

  task automatic test_saturate();
    int b = INIT_END + 8 * RI;
    logic [5:0] got, want;
    wait_to(INIT_END + 7 * RI);
    n_cmp++;
    if ({bus.ref_req, bus.ref_ovf} !== 2'b10) begin
      n_fail++; $display("FAIL seven_pending: req/ovf got %b want 10", {bus.ref_req, bus.ref_ovf});
    end
    wait_to(b);
    n_cmp++;
    if ({bus.ref_req, bus.ref_ovf} !== 2'b11) begin
      n_fail++; $display("FAIL overflow_set: req/ovf got %b want 11", {bus.ref_req, bus.ref_ovf});
    end
    bus.ref_gnt = 1'b1;
    for (int d = 1; d <= 64; d++) begin
      wait_to(b + d);
      want = {((d - 1) % 9 == 0 && d <= 55) ? 3'b001 : 3'b111,
              1'(d < 63 && d % 9 != 0), 1'(d < 63 && d % 9 == 0), 1'b1};
      got  = {cmd, bus.cmd_own, bus.ref_req, bus.ref_ovf};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL drain_cycle +%0d: cmd/own/req/ovf got %b want %b", d, got, want);
      end
    end
    bus.ref_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_tied();
    test_wrap_with_grant();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
